// File: rtl/sound_mixer_if.sv
// sound_mixer_if
//   Groups the codec-side handshake and the APU register/channel inputs
//   of the sound mixer into one bundle.
//   master : drives new_sample, channel_1..4, NR50/NR51/NR52; observes outputs
//   slave  : the mixer; consumes the inputs, drives hphone_l/hphone_r,
//            hphone_valid, busy and overrun
interface sound_mixer_if;
  logic        new_sample;
  logic [3:0]  channel_1;
  logic [3:0]  channel_2;
  logic [3:0]  channel_3;
  logic [3:0]  channel_4;
  logic [7:0]  NR50;
  logic [7:0]  NR51;
  logic [7:0]  NR52;
  logic [23:0] hphone_l;
  logic [23:0] hphone_r;
  logic        hphone_valid;
  logic        busy;
  logic        overrun;

  modport master (
    output new_sample, channel_1, channel_2, channel_3, channel_4,
    output NR50, NR51, NR52,
    input  hphone_l, hphone_r, hphone_valid, busy, overrun
  );

  modport slave (
    input  new_sample, channel_1, channel_2, channel_3, channel_4,
    input  NR50, NR51, NR52,
    output hphone_l, hphone_r, hphone_valid, busy, overrun
  );
endinterface

// File: rtl/sound_mixer.sv
// sound_mixer
//   Mixes four 4-bit APU channel amplitudes into a left/right 24-bit sample
//   on each codec request. Inputs are snapshotted at the request, summed per
//   side according to the panning enables, scaled by the master volume and
//   presented with a one-cycle valid strobe, 6 cycles after the request.
// Ports
//   system_clock : rising-edge clock for all state
//   reset        : synchronous, active-high reset
//   bus          : sound_mixer_if.slave (request, channels, NR50-52, outputs)
//
// state | meaning
// IDLE  | waiting for new_sample; the only state a mix may start from
// ACC   | 4 cycles, adds channel idx+1 to each enabled side accumulator
// SCALE | multiplies accumulators by (volume + 1), or zero if master off
// OUT   | loads hphone_l/hphone_r and raises hphone_valid for one cycle
module sound_mixer (
  input  logic          system_clock,
  input  logic          reset,
  sound_mixer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        start;
  logic        acc_step;
  logic        scale_step;
  logic        out_step;
  logic        busy_int;

  logic [1:0]  idx;
  logic [3:0]  snap_ch [4];
  logic [7:0]  snap_pan;
  logic [2:0]  snap_vol_l;
  logic [2:0]  snap_vol_r;
  logic        snap_en;

  logic [5:0]  acc_l;
  logic [5:0]  acc_r;
  logic [8:0]  scaled_l;
  logic [8:0]  scaled_r;

  logic [3:0]  ch_sel;
  logic        pan_l;
  logic        pan_r;
  logic [3:0]  gain_l;
  logic [3:0]  gain_r;
  logic [8:0]  mul_l;
  logic [8:0]  mul_r;

  // Register bits with no function in the mixer.
  logic        unused_bits;
  assign unused_bits = ^{bus.NR52[6:0], bus.NR50[7], bus.NR50[3]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    acc_step   = 1'b0;
    scale_step = 1'b0;
    out_step   = 1'b0;
    busy_int   = 1'b1;
    case (state)
      IDLE: begin
        busy_int = 1'b0;
        if (bus.new_sample) begin
          start     = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        acc_step = 1'b1;
        if (idx == 2'd3) begin
          state_nxt = SCALE;
        end
      end
      SCALE: begin
        scale_step = 1'b1;
        state_nxt  = OUT;
      end
      OUT: begin
        // Returning to IDLE this edge; a request seen now is still refused.
        out_step  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy = busy_int;

  // ----------------------------------------------------------- datapath
  assign ch_sel = snap_ch[idx];
  assign pan_l  = snap_pan[{1'b1, idx}];
  assign pan_r  = snap_pan[{1'b0, idx}];

  // Accumulators peak at 60 and gains at 8, so products fit 9 bits (<= 480).
  assign gain_l = {1'b0, snap_vol_l} + 4'd1;
  assign gain_r = {1'b0, snap_vol_r} + 4'd1;
  assign mul_l  = {3'b000, acc_l} * {5'b00000, gain_l};
  assign mul_r  = {3'b000, acc_r} * {5'b00000, gain_r};

  always_ff @(posedge system_clock) begin
    if (reset) begin
      idx              <= 2'd0;
      snap_ch[0]       <= 4'd0;
      snap_ch[1]       <= 4'd0;
      snap_ch[2]       <= 4'd0;
      snap_ch[3]       <= 4'd0;
      snap_pan         <= 8'd0;
      snap_vol_l       <= 3'd0;
      snap_vol_r       <= 3'd0;
      snap_en          <= 1'b0;
      acc_l            <= 6'd0;
      acc_r            <= 6'd0;
      scaled_l         <= 9'd0;
      scaled_r         <= 9'd0;
      bus.hphone_l     <= 24'd0;
      bus.hphone_r     <= 24'd0;
      bus.hphone_valid <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.hphone_valid <= 1'b0;
      bus.overrun      <= bus.new_sample & busy_int;

      if (start) begin
        snap_ch[0] <= bus.channel_1;
        snap_ch[1] <= bus.channel_2;
        snap_ch[2] <= bus.channel_3;
        snap_ch[3] <= bus.channel_4;
        snap_pan   <= bus.NR51;
        snap_vol_l <= bus.NR50[6:4];
        snap_vol_r <= bus.NR50[2:0];
        snap_en    <= bus.NR52[7];
        acc_l      <= 6'd0;
        acc_r      <= 6'd0;
        idx        <= 2'd0;
      end

      if (acc_step) begin
        if (pan_l) begin
          acc_l <= acc_l + {2'b00, ch_sel};
        end
        if (pan_r) begin
          acc_r <= acc_r + {2'b00, ch_sel};
        end
        // Wraps 3 -> 0 on the last channel, leaving idx ready for next mix.
        idx <= idx + 2'd1;
      end

      if (scale_step) begin
        scaled_l <= snap_en ? mul_l : 9'd0;
        scaled_r <= snap_en ? mul_r : 9'd0;
      end

      if (out_step) begin
        bus.hphone_l     <= {scaled_l, 15'd0};
        bus.hphone_r     <= {scaled_r, 15'd0};
        bus.hphone_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
module tb_sound_mixer;

  logic clk;
  logic reset;
  sound_mixer_if bus ();

  sound_mixer dut (
    .system_clock (clk),
    .reset        (reset),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp       = 0;
  int errs      = 0;
  int valid_cnt = 0;
  int ovr_cnt   = 0;
  bit checking  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural mix: sum enabled channels, scale by volume+1, left-justify.
  function automatic logic [23:0] mix(input logic [15:0] chs, input logic [7:0] nr50,
                                      input logic [7:0] nr51, input logic [7:0] nr52,
                                      input bit left);
    int s = 0;
    int vol;
    for (int i = 0; i < 4; i++) begin
      if (nr51[left ? 4 + i : i]) s += int'(chs[4*i +: 4]);
    end
    vol = left ? int'(nr50[6:4]) : int'(nr50[2:0]);
    if (!nr52[7]) return 24'd0;
    return 24'((s * (vol + 1)) * 32768);
  endfunction

  // Reference: a request accepted when idle completes 6 cycles later.
  int          phase = 0;
  logic [23:0] pend_l = 0, pend_r = 0;
  logic [23:0] m_l = 0, m_r = 0;
  logic        m_valid = 0, m_busy = 0, m_ovr = 0;

  always @(posedge clk) begin
    if (reset) begin
      phase = 0; m_l = 0; m_r = 0; m_valid = 0; m_busy = 0; m_ovr = 0;
    end else begin
      m_valid = 0;
      m_ovr   = bus.new_sample && (phase != 0);
      if (phase == 0) begin
        if (bus.new_sample) begin
          pend_l = mix({bus.channel_4, bus.channel_3, bus.channel_2, bus.channel_1},
                       bus.NR50, bus.NR51, bus.NR52, 1'b1);
          pend_r = mix({bus.channel_4, bus.channel_3, bus.channel_2, bus.channel_1},
                       bus.NR50, bus.NR51, bus.NR52, 1'b0);
          phase = 1;
        end
      end else if (phase == 6) begin
        m_l = pend_l; m_r = pend_r; m_valid = 1; phase = 0;
      end else begin
        phase++;
      end
      m_busy = (phase != 0);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("hphone_valid", 32'(bus.hphone_valid), 32'(m_valid));
      chk("busy",         32'(bus.busy),         32'(m_busy));
      chk("overrun",      32'(bus.overrun),      32'(m_ovr));
      chk("hphone_l",     32'(bus.hphone_l),     32'(m_l));
      chk("hphone_r",     32'(bus.hphone_r),     32'(m_r));
      if (bus.hphone_valid) valid_cnt++;
      if (bus.overrun) ovr_cnt++;
    end
  end

  task automatic set_in(input logic [3:0] c1, c2, c3, c4, input logic [7:0] n50, n51, n52);
    bus.channel_1 = c1; bus.channel_2 = c2; bus.channel_3 = c3; bus.channel_4 = c4;
    bus.NR50 = n50; bus.NR51 = n51; bus.NR52 = n52;
  endtask

  task automatic pulse();
    @(negedge clk) bus.new_sample = 1'b1;
    @(negedge clk) bus.new_sample = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.hphone_valid) lat = k;
    end
    if (lat < 0) chk("valid_timeout", 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic directed(input string name, input logic [23:0] el, input logic [23:0] er);
    int lat;
    pulse();
    wait_valid(lat);
    chk({name, "_latency"}, 32'(lat), 32'd6);
    chk({name, "_l"}, 32'(bus.hphone_l), 32'(el));
    chk({name, "_r"}, 32'(bus.hphone_r), 32'(er));
    chk({name, "_model_l"}, 32'(m_l), 32'(el));
    chk({name, "_model_r"}, 32'(m_r), 32'(er));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat, v0, o0, busy_cycles;
    reset = 1'b1;
    bus.new_sample = 1'b0;
    set_in(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    checking = 1'b1;
    chk("rst_l", 32'(bus.hphone_l), 32'd0);
    chk("rst_valid", 32'(bus.hphone_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Full scale, with busy-width measurement.
    set_in(15, 15, 15, 15, 8'h77, 8'hFF, 8'h80);
    pulse();
    busy_cycles = 1;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      if (bus.hphone_valid) lat = k;
    end
    chk("full_latency", 32'(lat), 32'd6);
    chk("full_busy_cycles", 32'(busy_cycles), 32'd6);
    chk("full_l", 32'(bus.hphone_l), 32'hF00000);
    chk("full_r", 32'(bus.hphone_r), 32'hF00000);
    chk("full_model_l", 32'(m_l), 32'hF00000);
    repeat (2) @(negedge clk);

    set_in(5, 9, 15, 15, 8'h30, 8'h12, 8'h80);
    directed("pan_vol", 24'h0A0000, 24'h048000);
    set_in(15, 15, 15, 15, 8'h77, 8'hFF, 8'h00);
    directed("master_off", 24'h000000, 24'h000000);
    set_in(15, 15, 15, 15, 8'hF7, 8'hFF, 8'h7F);
    directed("ignored_bits", 24'h000000, 24'h000000);

    // Snapshot and overrun.
    set_in(15, 15, 15, 15, 8'h77, 8'hFF, 8'h80);
    @(negedge clk); #1 o0 = ovr_cnt;
    @(negedge clk) bus.new_sample = 1'b1;
    @(negedge clk) bus.new_sample = 1'b0;
    @(negedge clk) begin set_in(0, 0, 0, 0, 8'h77, 8'hFF, 8'h80); bus.new_sample = 1'b1; end
    @(negedge clk) bus.new_sample = 1'b0;
    wait_valid(lat);
    chk("snap_latency", 32'(lat), 32'd4);
    chk("snap_l", 32'(bus.hphone_l), 32'hF00000);
    chk("snap_r", 32'(bus.hphone_r), 32'hF00000);
    repeat (3) @(negedge clk);
    #1 chk("snap_overruns", 32'(ovr_cnt - o0), 32'd1);

    // Reset mid-mix.
    set_in(7, 3, 1, 2, 8'h25, 8'h5A, 8'h80);
    pulse();
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) begin
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_l", 32'(bus.hphone_l), 32'd0);
      reset = 1'b0;
    end
    #1 v0 = valid_cnt;
    repeat (10) @(negedge clk);
    #1 chk("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
    set_in(15, 15, 15, 15, 8'h77, 8'hFF, 8'h80);
    directed("after_rst", 24'hF00000, 24'hF00000);

    // Back-to-back every 7 cycles, then every 6 cycles.
    #1 begin v0 = valid_cnt; o0 = ovr_cnt; end
    for (int n = 0; n < 10; n++) begin
      set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             8'($urandom), 8'($urandom), 8'h80);
      pulse();
      repeat (5) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    #1 chk("b2b7_valids", 32'(valid_cnt - v0), 32'd10);
    chk("b2b7_overruns", 32'(ovr_cnt - o0), 32'd0);
    v0 = valid_cnt; o0 = ovr_cnt;
    for (int n = 0; n < 10; n++) begin
      pulse();
      repeat (4) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    #1 chk("b2b6_valids", 32'(valid_cnt - v0), 32'd5);
    chk("b2b6_overruns", 32'(ovr_cnt - o0), 32'd5);

    // Random traffic, inputs wiggling during mixes, occasional reset.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      bus.new_sample = ($urandom_range(0, 3) == 0);
      set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom));
    end
    @(negedge clk) begin reset = 1'b0; bus.new_sample = 1'b0; end
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
